// File: rtl/evt_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : evt_counter_multi
//  Purpose  : Parametrised multi-channel event counter. Each channel counts
//             modulo MAX_COUNT, up or down, and either wraps or saturates at
//             its bound. It supports synchronous clear and load, and emits a
//             registered one-cycle terminal-count pulse. With CASCADE=1 each
//             channel above channel 0 counts the carries of the channel below
//             it, and a full ripple resolves on a single clock edge.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in       in   1         system clock, rising edge
//    rst_n_in     in   1         asynchronous active-low reset
//    clr_in       in   NUM_CH    per-channel synchronous clear
//    load_in      in   NUM_CH    per-channel synchronous load
//    load_val_in  in   NUM_CH*W  load values, channel i at [i*W +: W]
//    evt_in       in   NUM_CH    count events (i>0 ignored when CASCADE=1)
//    dir_in       in   NUM_CH    1 = up, 0 = down
//    sat_in       in   NUM_CH    1 = saturate at bound, 0 = wrap
//    count_out    out  NUM_CH*W  registered counts, channel i at [i*W +: W]
//    term_out     out  NUM_CH    one-cycle terminal-event pulses
// ============================================================================
module evt_counter_multi #(
  parameter int MAX_COUNT = 640,
  parameter int NUM_CH    = 2,
  parameter int CASCADE   = 0,
  localparam int W        = $clog2(MAX_COUNT)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NUM_CH-1:0]   clr_in,
  input  logic [NUM_CH-1:0]   load_in,
  input  logic [NUM_CH*W-1:0] load_val_in,
  input  logic [NUM_CH-1:0]   evt_in,
  input  logic [NUM_CH-1:0]   dir_in,
  input  logic [NUM_CH-1:0]   sat_in,
  output logic [NUM_CH*W-1:0] count_out,
  output logic [NUM_CH-1:0]   term_out
);

  // Top of the count range. MAX_COUNT need not be a power of two, so the
  // wrap point is always detected by explicit comparison against this value.
  localparam logic [W-1:0] TOP_VAL = W'(MAX_COUNT - 1);
  localparam logic [W-1:0] ONE_VAL = W'(1);

  logic [W-1:0]      count_q [NUM_CH];
  logic [W-1:0]      count_d [NUM_CH];
  logic [NUM_CH-1:0] term_q;
  logic [NUM_CH-1:0] tev;

  // --------------------------------------------------------------------------
  // Next-state logic. Channels are evaluated from 0 upward so that the carry
  // of channel i-1 is already known when channel i is evaluated; the carry
  // chain is purely combinational, which keeps the latency at one cycle for
  // every channel.
  // --------------------------------------------------------------------------
  always_comb begin
    logic         carry_prev;
    logic         carry_cur;
    logic         eff;
    logic         at_bound;
    logic [W-1:0] cur;
    logic [W-1:0] bound;
    logic [W-1:0] lval;

    carry_prev = 1'b0;
    carry_cur  = 1'b0;
    eff        = 1'b0;
    at_bound   = 1'b0;
    cur        = '0;
    bound      = '0;
    lval       = '0;
    tev        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i] = '0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      cur   = count_q[i];
      lval  = load_val_in[i*W +: W];
      bound = dir_in[i] ? TOP_VAL : '0;

      // Channel 0 always takes its own event input; higher channels follow
      // the carry of the channel below when cascaded.
      if ((CASCADE != 0) && (i > 0)) begin
        eff = carry_prev;
      end else begin
        eff = evt_in[i];
      end

      at_bound = (cur == bound);

      // Clear and load suppress the terminal event, and with it any carry,
      // so they can never step the next channel up the chain.
      tev[i]    = eff & at_bound & ~clr_in[i] & ~load_in[i];
      carry_cur = tev[i] & ~sat_in[i];

      if (clr_in[i]) begin
        count_d[i] = '0;
      end else if (load_in[i]) begin
        // Out-of-range load values clamp to the top of the range.
        count_d[i] = (lval > TOP_VAL) ? TOP_VAL : lval;
      end else if (!eff) begin
        count_d[i] = cur;
      end else if (!at_bound) begin
        count_d[i] = dir_in[i] ? (cur + ONE_VAL) : (cur - ONE_VAL);
      end else if (!sat_in[i]) begin
        count_d[i] = dir_in[i] ? '0 : TOP_VAL;
      end else begin
        count_d[i] = cur;
      end

      carry_prev = carry_cur;
    end
  end

  // --------------------------------------------------------------------------
  // State registers. Reset clears every count and drops any pending pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
      end
      term_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= count_d[i];
      end
      term_q <= tev;
    end
  end

  // Pack the per-channel registers onto the flat output bus.
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign count_out[g*W +: W] = count_q[g];
    end
  endgenerate

  assign term_out = term_q;

endmodule
`default_nettype wire

// File: tb/tb_evt_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_evt_counter_multi
//  Purpose  : Self-checking bench for evt_counter_multi. Two instances share
//             the same stimulus: dut_a runs independent channels (CASCADE=0)
//             and dut_b chains its channels (CASCADE=1). Expected states are
//             queued as stimulus is applied and compared once sampled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_evt_counter_multi;

  localparam int MAXC = 640;
  localparam int NCH  = 2;
  localparam int W    = 10;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic [NCH-1:0] clr_in, load_in, evt_in, dir_in, sat_in;
  logic [NCH*W-1:0] load_val_in;
  logic [NCH*W-1:0] cnt_a, cnt_b;
  logic [NCH-1:0]   term_a, term_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a0, a1, b0, b1;
    logic [1:0]   ta, tb;
    string        name;
  } snap_t;

  snap_t sb[$];
  snap_t obs[$];

  always #5 clk_in = ~clk_in;

  evt_counter_multi #(.MAX_COUNT(MAXC), .NUM_CH(NCH), .CASCADE(0)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr_in), .load_in(load_in),
    .load_val_in(load_val_in), .evt_in(evt_in), .dir_in(dir_in), .sat_in(sat_in),
    .count_out(cnt_a), .term_out(term_a)
  );

  evt_counter_multi #(.MAX_COUNT(MAXC), .NUM_CH(NCH), .CASCADE(1)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr_in), .load_in(load_in),
    .load_val_in(load_val_in), .evt_in(evt_in), .dir_in(dir_in), .sat_in(sat_in),
    .count_out(cnt_b), .term_out(term_b)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Queue the expected post-edge state, clock once, then record the sample.
  task automatic step(input string n, input int a0, input int a1, input logic [1:0] ta,
                      input int b0, input int b1, input logic [1:0] tb);
    snap_t e, o;
    e.name = n;
    e.a0 = W'(a0); e.a1 = W'(a1); e.ta = ta;
    e.b0 = W'(b0); e.b1 = W'(b1); e.tb = tb;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    o.name = n;
    o.a0 = cnt_a[W-1:0]; o.a1 = cnt_a[2*W-1:W]; o.ta = term_a;
    o.b0 = cnt_b[W-1:0]; o.b1 = cnt_b[2*W-1:W]; o.tb = term_b;
    obs.push_back(o);
  endtask

  task automatic idle();
    clr_in = '0; load_in = '0; evt_in = '0; dir_in = 2'b11; sat_in = '0;
    load_val_in = '0;
  endtask

  task automatic test_reset();
    snap_t e, o;
    rst_n_in = 1'b0;
    idle();
    tick();
    step("reset_hold", 0, 0, 2'b00, 0, 0, 2'b00);
    rst_n_in = 1'b1;
    step("reset_release", 0, 0, 2'b00, 0, 0, 2'b00);
    load_in = 2'b01; load_val_in = {10'd0, 10'd123};
    step("load_123", 123, 0, 2'b00, 123, 0, 2'b00);
    load_in = '0;
    // Drop reset between edges: outputs must clear without a clock edge.
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({cnt_a, term_a, cnt_b, term_b} !== '0) begin
      errors++;
      $display("FAIL async_reset: a=%h/%b b=%h/%b, want all zero", cnt_a, term_a, cnt_b, term_b);
    end
    tick();
    rst_n_in = 1'b1;
    evt_in = 2'b01;
    step("post_reset_evt", 1, 0, 2'b00, 1, 0, 2'b00);
    evt_in = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_up_wrap();
    snap_t e, o;
    idle();
    load_in = 2'b01; load_val_in = {10'd0, 10'd638};
    step("uw_load", 638, 0, 2'b00, 638, 0, 2'b00);
    load_in = '0; evt_in = 2'b01;
    step("uw_639", 639, 0, 2'b00, 639, 0, 2'b00);
    step("uw_wrap", 0, 0, 2'b01, 0, 1, 2'b01);
    evt_in = '0;
    step("uw_idle", 0, 0, 2'b00, 0, 1, 2'b00);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_cascade();
    snap_t e, o;
    idle();
    load_in = 2'b11; load_val_in = {10'd5, 10'd639};
    step("cc_load", 639, 5, 2'b00, 639, 5, 2'b00);
    load_in = '0; evt_in = 2'b11;
    step("cc_ripple", 0, 6, 2'b01, 0, 6, 2'b01);
    evt_in = 2'b10;
    step("cc_evt1_only", 0, 7, 2'b00, 0, 6, 2'b00);
    evt_in = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_saturate();
    snap_t e, o;
    idle();
    sat_in = 2'b01;
    load_in = 2'b11; load_val_in = {10'd6, 10'd639};
    step("sat_load", 639, 6, 2'b00, 639, 6, 2'b00);
    load_in = '0; evt_in = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step($sformatf("sat_hold_%0d", k), 639, 6, 2'b01, 639, 6, 2'b01);
    end
    evt_in = '0;
    step("sat_idle", 639, 6, 2'b00, 639, 6, 2'b00);
    sat_in = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_down_wrap();
    snap_t e, o;
    idle();
    dir_in = 2'b10;   // ch0 counts down, ch1 counts up
    load_in = 2'b11; load_val_in = {10'd6, 10'd0};
    step("dw_load", 0, 6, 2'b00, 0, 6, 2'b00);
    load_in = '0; evt_in = 2'b01;
    step("dw_wrap", 639, 6, 2'b01, 639, 7, 2'b01);
    step("dw_dec", 638, 6, 2'b00, 638, 7, 2'b00);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_priority();
    snap_t e, o;
    idle();
    clr_in = 2'b01; load_in = 2'b01; load_val_in = {10'd0, 10'd100}; evt_in = 2'b01;
    step("pr_clr_wins", 0, 6, 2'b00, 0, 7, 2'b00);
    clr_in = '0; load_in = 2'b01; load_val_in = {10'd0, 10'd1000}; evt_in = '0;
    step("pr_clamp", 639, 6, 2'b00, 639, 7, 2'b00);
    load_in = '0; evt_in = 2'b01; clr_in = 2'b10;
    step("pr_clr_drops_carry", 0, 0, 2'b01, 0, 0, 2'b01);
    clr_in = '0; evt_in = '0;
    step("pr_carry_not_deferred", 0, 0, 2'b00, 0, 0, 2'b00);
    load_in = 2'b01; load_val_in = {10'd0, 10'd639}; evt_in = 2'b01;
    step("pr_load_no_term", 639, 0, 2'b00, 639, 0, 2'b00);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    idle();
    load_in = 2'b10; load_val_in = {10'd639, 10'd0};
    step("bb_load1", 639, 639, 2'b00, 639, 639, 2'b00);
    load_in = '0; evt_in = 2'b01;
    // Full ripple in dut_b: both channels wrap on the same edge.
    step("bb_full_ripple", 0, 639, 2'b01, 0, 0, 2'b11);
    evt_in = 2'b11;
    step("bb_next", 1, 0, 2'b10, 1, 0, 2'b00);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL %s: no sample recorded", e.name);
      end else begin
        o = obs.pop_front();
        if ({o.a0, o.a1, o.ta, o.b0, o.b1, o.tb} !== {e.a0, e.a1, e.ta, e.b0, e.b1, e.tb}) begin
          errors++;
          $display("FAIL %s: got a=%0d,%0d t=%b b=%0d,%0d t=%b; want a=%0d,%0d t=%b b=%0d,%0d t=%b",
                   e.name, o.a0, o.a1, o.ta, o.b0, o.b1, o.tb, e.a0, e.a1, e.ta, e.b0, e.b1, e.tb);
        end
      end
    end
    obs.delete();
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle();
    test_reset();
    test_up_wrap();
    test_cascade();
    test_saturate();
    test_down_wrap();
    test_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
